// File: rtl/median_column_feeder.sv
`default_nettype none
// ============================================================================
// Module  : median_column_feeder
// Purpose : Streaming 3-row column generator (two line buffers) feeding the
//           3x3 median column-sort stage from a raster-order pixel stream.
// Revision: 1.0  initial release
// ============================================================================
module median_column_feeder #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 640,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    input  logic              pix_sof,
    output logic              pix_ready,
    output logic [DATA_W-1:0] x2_y1,
    output logic [DATA_W-1:0] x2_y0,
    output logic [DATA_W-1:0] x2_ym1,
    output logic [ADDR_W-1:0] col_x,
    output logic              col_eol,
    output logic              col_valid,
    input  logic              col_ready
);
    localparam logic [ADDR_W-1:0] LAST_X    = ADDR_W'(IMG_W - 1);
    localparam logic [1:0]        ROWS_FULL = 2'd2;

    logic [DATA_W-1:0] lb_mid [IMG_W];
    logic [DATA_W-1:0] lb_old [IMG_W];

    logic [ADDR_W-1:0] x_cnt;
    logic [1:0]        row_cnt;
    logic              accept;
    logic [ADDR_W-1:0] x_cur;
    logic [1:0]        row_cur;
    logic              last_col;
    logic [DATA_W-1:0] mid_rd;
    logic [DATA_W-1:0] old_rd;

    assign pix_ready = ~col_valid | col_ready;
    assign accept    = pix_valid & pix_ready;

    // A start-of-frame pixel overrides the counters for its own cycle.
    assign x_cur    = pix_sof ? '0 : x_cnt;
    assign row_cur  = pix_sof ? 2'd0 : row_cnt;
    assign last_col = (x_cur == LAST_X);
    assign mid_rd   = lb_mid[x_cur];
    assign old_rd   = lb_old[x_cur];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_cnt     <= '0;
            row_cnt   <= 2'd0;
            col_valid <= 1'b0;
            x2_y1     <= '0;
            x2_y0     <= '0;
            x2_ym1    <= '0;
            col_x     <= '0;
            col_eol   <= 1'b0;
        end else if (accept) begin
            x2_y1     <= pix_in;
            x2_y0     <= mid_rd;
            x2_ym1    <= old_rd;
            col_x     <= x_cur;
            col_eol   <= last_col;
            col_valid <= (row_cur == ROWS_FULL);
            if (last_col) begin
                x_cnt   <= '0;
                row_cnt <= (row_cur == ROWS_FULL) ? ROWS_FULL : row_cur + 2'd1;
            end else begin
                x_cnt   <= x_cur + ADDR_W'(1);
                row_cnt <= row_cur;
            end
        end else if (col_ready) begin
            col_valid <= 1'b0;
        end
    end

    // Contents are never cleared; row_cnt keeps stale data from being emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_old[x_cur] <= mid_rd;
            lb_mid[x_cur] <= pix_in;
        end
    end

endmodule
`default_nettype wire
